// File: rtl/core_mem_pkg.sv
// Shared types and default sizes for the core memory arbiter.
package core_mem_pkg;

  // Which core port a memory transaction belongs to.
  typedef enum logic {
    SRC_INSTR = 1'b0,
    SRC_DATA  = 1'b1
  } mem_src_e;

  // Default widths used by the arbiter and its response FIFO.
  localparam int unsigned CORE_MEM_ADDR_W          = 32;
  localparam int unsigned CORE_MEM_DATA_W          = 32;
  localparam int unsigned CORE_MEM_MAX_OUTSTANDING = 2;

  // The source that did not win last time; used to break ties.
  function automatic mem_src_e other_src(input mem_src_e s);
    return (s == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
  endfunction

endpackage

// File: rtl/arb_resp_fifo.sv
// Small in-order FIFO holding the source ID of every granted transaction,
// so each memory response can be routed back to the port that issued it.
// The head is readable combinationally so responses route in zero cycles.
module arb_resp_fifo
  import core_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  mem_src_e                     push_src_i,
  input  logic                         pop_i,
  output mem_src_e                     head_src_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  mem_src_e           r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;

  // Pointers wrap modulo DEPTH; DEPTH=1 keeps both pointers pinned at 0.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  // Guard against overflow/underflow even if a caller misbehaves.
  assign w_push  = push_i & ~w_full;
  assign w_pop   = pop_i & ~w_empty;

  // Storage write; contents need no reset because count marks validity.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_src_i;
    end
  end

  // Pointer and occupancy tracking; count separates full from empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head_src_o = r_mem[r_rd_ptr];
  assign full_o     = w_full;
  assign empty_o    = w_empty;
  assign count_o    = r_count;

endmodule

// File: rtl/core_mem_arbiter.sv
// Shares one single-ported memory between the core's fetch and data ports.
// Round-robin arbitration, a stall lock that keeps a refused request on the
// bus until it is granted, and in-order response routing via a source FIFO.
module core_mem_arbiter
  import core_mem_pkg::*;
#(
  parameter int unsigned ADDR_W          = CORE_MEM_ADDR_W,
  parameter int unsigned DATA_W          = CORE_MEM_DATA_W,
  parameter int unsigned MAX_OUTSTANDING = CORE_MEM_MAX_OUTSTANDING
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  // instruction fetch port
  input  logic                                   instr_req_i,
  input  logic [ADDR_W-1:0]                      instr_addr_i,
  output logic                                   instr_gnt_o,
  output logic                                   instr_rvalid_o,
  output logic [DATA_W-1:0]                      instr_rdata_o,
  // load/store port
  input  logic                                   data_req_i,
  input  logic [ADDR_W-1:0]                      data_addr_i,
  input  logic                                   data_we_i,
  input  logic [DATA_W/8-1:0]                    data_be_i,
  input  logic [DATA_W-1:0]                      data_wdata_i,
  output logic                                   data_gnt_o,
  output logic                                   data_rvalid_o,
  output logic [DATA_W-1:0]                      data_rdata_o,
  // memory side
  output logic                                   mem_req_o,
  output logic [ADDR_W-1:0]                      mem_addr_o,
  output logic                                   mem_we_o,
  output logic [DATA_W/8-1:0]                    mem_be_o,
  output logic [DATA_W-1:0]                      mem_wdata_o,
  input  logic                                   mem_gnt_i,
  input  logic                                   mem_rvalid_i,
  input  logic [DATA_W-1:0]                      mem_rdata_i,
  // status
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   err_o
);

  mem_src_e r_last_src;
  mem_src_e r_lock_src;
  logic     r_lock_vld;
  logic     r_err;

  mem_src_e w_sel_src;
  mem_src_e w_head_src;
  logic     w_lock_active;
  logic     w_any_req;
  logic     w_fifo_full;
  logic     w_fifo_empty;
  logic     w_mem_req;
  logic     w_grant;
  logic     w_pop;
  logic     w_spurious;

  // A lock only holds while its owner keeps requesting; a dropped request
  // is a withdrawal and arbitration falls back to the normal rules.
  always_comb begin
    w_lock_active = 1'b0;
    if (r_lock_vld) begin
      w_lock_active = (r_lock_src == SRC_INSTR) ? instr_req_i : data_req_i;
    end
  end

  // Source selection: live lock first, then sole requester, then whoever
  // did not win last time.
  always_comb begin
    w_sel_src = SRC_DATA;
    if (w_lock_active) begin
      w_sel_src = r_lock_src;
    end else if (instr_req_i && data_req_i) begin
      w_sel_src = other_src(r_last_src);
    end else if (instr_req_i) begin
      w_sel_src = SRC_INSTR;
    end else begin
      w_sel_src = SRC_DATA;
    end
  end

  assign w_any_req = instr_req_i | data_req_i;

  // Internal request/grant drive the state; reset gating is applied only on
  // the outputs since every register is already held by the async reset.
  assign w_mem_req = w_any_req & ~w_fifo_full;
  assign w_grant   = w_mem_req & mem_gnt_i;

  // Request payload mux; fetches are always full-word reads.
  always_comb begin
    mem_addr_o  = data_addr_i;
    mem_we_o    = data_we_i;
    mem_be_o    = data_be_i;
    mem_wdata_o = data_wdata_i;
    if (w_sel_src == SRC_INSTR) begin
      mem_addr_o  = instr_addr_i;
      mem_we_o    = 1'b0;
      mem_be_o    = {(DATA_W/8){1'b1}};
      mem_wdata_o = '0;
    end
  end

  assign mem_req_o   = w_mem_req & ~rst_i;
  assign instr_gnt_o = w_grant & ~rst_i & (w_sel_src == SRC_INSTR);
  assign data_gnt_o  = w_grant & ~rst_i & (w_sel_src == SRC_DATA);

  // Responses are matched to the oldest outstanding ID; a response with
  // nothing outstanding is a protocol error and is not routed anywhere.
  assign w_pop      = mem_rvalid_i & ~w_fifo_empty;
  assign w_spurious = mem_rvalid_i & w_fifo_empty;

  assign instr_rvalid_o = w_pop & ~rst_i & (w_head_src == SRC_INSTR);
  assign data_rvalid_o  = w_pop & ~rst_i & (w_head_src == SRC_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

  // Round-robin history: remember who won the most recent grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last_src <= SRC_DATA;
    end else if (w_grant) begin
      r_last_src <= w_sel_src;
    end
  end

  // Stall lock: a refused request keeps its source selected until granted
  // or withdrawn.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lock_vld <= 1'b0;
      r_lock_src <= SRC_INSTR;
    end else if (w_mem_req && !mem_gnt_i) begin
      r_lock_vld <= 1'b1;
      r_lock_src <= w_sel_src;
    end else if (w_grant) begin
      r_lock_vld <= 1'b0;
    end else if (r_lock_vld && !w_lock_active) begin
      r_lock_vld <= 1'b0;
    end
  end

  // Sticky error flag for responses that arrive with nothing outstanding.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (w_spurious) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;

  arb_resp_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_resp_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (w_grant),
    .push_src_i (w_sel_src),
    .pop_i      (w_pop),
    .head_src_o (w_head_src),
    .full_o     (w_fifo_full),
    .empty_o    (w_fifo_empty),
    .count_o    (outstanding_o)
  );

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: directed table, corner-case sequences and a
// randomized run against a queue-based reference model.
module tb_core_mem_arbiter;
  import core_mem_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 2;
  localparam int CW = $clog2(MO + 1);

  logic            clk_i;
  logic            rst_i;
  logic            instr_req_i;
  logic [AW-1:0]   instr_addr_i;
  logic            instr_gnt_o;
  logic            instr_rvalid_o;
  logic [DW-1:0]   instr_rdata_o;
  logic            data_req_i;
  logic [AW-1:0]   data_addr_i;
  logic            data_we_i;
  logic [DW/8-1:0] data_be_i;
  logic [DW-1:0]   data_wdata_i;
  logic            data_gnt_o;
  logic            data_rvalid_o;
  logic [DW-1:0]   data_rdata_o;
  logic            mem_req_o;
  logic [AW-1:0]   mem_addr_o;
  logic            mem_we_o;
  logic [DW/8-1:0] mem_be_o;
  logic [DW-1:0]   mem_wdata_o;
  logic            mem_gnt_i;
  logic            mem_rvalid_i;
  logic [DW-1:0]   mem_rdata_i;
  logic [CW-1:0]   outstanding_o;
  logic            err_o;

  core_mem_arbiter #(
    .ADDR_W          (AW),
    .DATA_W          (DW),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .data_req_i     (data_req_i),
    .data_addr_i    (data_addr_i),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_wdata_i   (data_wdata_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .outstanding_o  (outstanding_o),
    .err_o          (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // in = {instr_req, data_req, mem_gnt, mem_rvalid}
  // ex = {mem_req, instr_gnt, data_gnt, instr_rvalid, data_rvalid}
  typedef struct {
    logic [3:0]  in;
    logic [31:0] rdata;
    logic [4:0]  ex;
    logic [31:0] e_addr;
    int          e_out;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic dr, input logic g, input logic rv,
                       input logic [31:0] rd);
    instr_req_i  = ir;
    data_req_i   = dr;
    mem_gnt_i    = g;
    mem_rvalid_i = rv;
    mem_rdata_i  = rd;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Compare the five handshake outputs and occupancy against one record.
  task automatic chk_hs(input string tag, input logic [4:0] ex, input int out);
    chk($sformatf("%s.mem_req", tag),      64'(mem_req_o),      64'(ex[4]));
    chk($sformatf("%s.instr_gnt", tag),    64'(instr_gnt_o),    64'(ex[3]));
    chk($sformatf("%s.data_gnt", tag),     64'(data_gnt_o),     64'(ex[2]));
    chk($sformatf("%s.instr_rvalid", tag), 64'(instr_rvalid_o), 64'(ex[1]));
    chk($sformatf("%s.data_rvalid", tag),  64'(data_rvalid_o),  64'(ex[0]));
    chk($sformatf("%s.outstanding", tag),  64'(outstanding_o),  64'(out));
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic fixed_payload();
    instr_addr_i = 32'h0000_0100;
    data_addr_i  = 32'h0000_0200;
    data_we_i    = 1'b1;
    data_be_i    = 4'h3;
    data_wdata_i = 32'hCAFE_0001;
  endtask

  // Reference model state: outstanding source IDs (0=instr, 1=data).
  int m_q[$];
  int m_last;
  int m_lock_vld;
  int m_lock_src;
  int m_err;

  initial begin
    tbl[0] = '{4'b1010, 32'h0000_0000, 5'b11000, 32'h100, 0};
    tbl[1] = '{4'b0001, 32'hDEAD_BEEF, 5'b00010, 32'h000, 1};
    tbl[2] = '{4'b1110, 32'h0000_0000, 5'b10100, 32'h200, 0};
    tbl[3] = '{4'b1111, 32'h1111_1111, 5'b11001, 32'h100, 1};
    tbl[4] = '{4'b1111, 32'h2222_2222, 5'b10110, 32'h200, 1};
    tbl[5] = '{4'b1101, 32'h3333_3333, 5'b10001, 32'h100, 1};
    tbl[6] = '{4'b0110, 32'h0000_0000, 5'b10100, 32'h200, 0};
    tbl[7] = '{4'b0001, 32'h4444_4444, 5'b00001, 32'h000, 1};

    fixed_payload();
    rst_i = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h5555_5555);
    #3;
    // Outputs forced quiet while reset is asserted.
    chk_hs("reset", 5'b00000, 0);
    chk("reset.err", 64'(err_o), 64'(0));
    tick();
    do_reset();

    // ---------------- directed table ----------------
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0], tbl[i].rdata);
      #4;
      chk_hs($sformatf("tbl%0d", i), tbl[i].ex, tbl[i].e_out);
      chk($sformatf("tbl%0d.instr_rdata", i), 64'(instr_rdata_o), 64'(tbl[i].rdata));
      chk($sformatf("tbl%0d.data_rdata", i),  64'(data_rdata_o),  64'(tbl[i].rdata));
      chk($sformatf("tbl%0d.err", i), 64'(err_o), 64'(0));
      if (tbl[i].ex[4]) begin
        chk($sformatf("tbl%0d.addr", i), 64'(mem_addr_o), 64'(tbl[i].e_addr));
        if (tbl[i].e_addr == 32'h100) begin
          chk($sformatf("tbl%0d.we", i),    64'(mem_we_o),    64'(0));
          chk($sformatf("tbl%0d.be", i),    64'(mem_be_o),    64'(4'hF));
          chk($sformatf("tbl%0d.wdata", i), 64'(mem_wdata_o), 64'(0));
        end else begin
          chk($sformatf("tbl%0d.we", i),    64'(mem_we_o),    64'(1));
          chk($sformatf("tbl%0d.be", i),    64'(mem_be_o),    64'(4'h3));
          chk($sformatf("tbl%0d.wdata", i), 64'(mem_wdata_o), 64'(32'hCAFE_0001));
        end
      end
      $display("tbl%0d: req=%0b igt=%0b dgt=%0b irv=%0b drv=%0b out=%0d", i,
               mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, outstanding_o);
      tick();
    end

    // ---------------- stall lock ----------------
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    #4;
    chk_hs("lock0", 5'b10000, 0);
    chk("lock0.addr", 64'(mem_addr_o), 64'(32'h200));
    chk("lock0.we", 64'(mem_we_o), 64'(1));
    $display("lock0: data store stalled");
    tick();
    for (int c = 1; c < 3; c++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      #4;
      chk_hs($sformatf("lock%0d", c), 5'b10000, 0);
      chk($sformatf("lock%0d.addr", c), 64'(mem_addr_o), 64'(32'h200));
      $display("lock%0d: instr waiting behind locked store", c);
      tick();
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    #4;
    chk_hs("lock3", 5'b10100, 0);
    chk("lock3.addr", 64'(mem_addr_o), 64'(32'h200));
    $display("lock3: store granted");
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    #4;
    chk_hs("lock4", 5'b11000, 1);
    chk("lock4.addr", 64'(mem_addr_o), 64'(32'h100));
    $display("lock4: fetch granted");
    tick();

    // ---------------- full ----------------
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    #4; chk_hs("full0", 5'b11000, 0); $display("full0: grant instr"); tick();
    #4; chk_hs("full1", 5'b10100, 1); $display("full1: grant data"); tick();
    #4; chk_hs("full2", 5'b00000, 2); $display("full2: blocked"); tick();
    #4; chk_hs("full3", 5'b00000, 2); $display("full3: blocked"); tick();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hA5A5_A5A5);
    #4; chk_hs("full4", 5'b00010, 2);
    chk("full4.instr_rdata", 64'(instr_rdata_o), 64'(32'hA5A5_A5A5));
    $display("full4: pop, still blocked"); tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    #4; chk_hs("full5", 5'b11000, 1); $display("full5: grant resumes"); tick();

    // ---------------- reset mid-operation ----------------
    chk("rstmid.pre_outstanding", 64'(outstanding_o), 64'(2));
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h7777_7777);
    #1 rst_i = 1'b1;
    #1;
    chk_hs("rstmid", 5'b00000, 0);
    chk("rstmid.err", 64'(err_o), 64'(0));
    #1 rst_i = 1'b0;
    mem_rvalid_i = 1'b0;
    #1;
    chk_hs("rstrel", 5'b11000, 0);
    $display("rstmid: reset pulse, then tie grants instr");
    tick();

    // ---------------- spurious response ----------------
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hBEEF_0001);
    #4; chk_hs("spur0", 5'b00010, 1); chk("spur0.err", 64'(err_o), 64'(0));
    $display("spur0: legit response"); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hBEEF_0002);
    #4; chk_hs("spur1", 5'b00000, 0); chk("spur1.err", 64'(err_o), 64'(0));
    $display("spur1: late response, nothing outstanding"); tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    #4; chk_hs("spur2", 5'b11000, 0); chk("spur2.err", 64'(err_o), 64'(1));
    $display("spur2: err raised"); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hBEEF_0003);
    #4; chk_hs("spur3", 5'b00010, 1); chk("spur3.err", 64'(err_o), 64'(1));
    $display("spur3: err sticky"); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #4; chk("spur4.err", 64'(err_o), 64'(1));
    $display("spur4: err sticky"); tick();

    // ---------------- randomized vs reference model ----------------
    do_reset();
    m_q.delete();
    m_last     = 1;
    m_lock_vld = 0;
    m_lock_src = 0;
    m_err      = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int   sel;
      logic ir, dr, g, rv, lreq, e_req, e_gr, e_pop;
      logic [4:0] ex;
      int   e_out;
      ir = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      g  = ($urandom_range(0, 2) != 0);
      rv = (m_q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
      instr_addr_i = $urandom;
      data_addr_i  = $urandom;
      data_we_i    = 1'($urandom_range(0, 1));
      data_be_i    = 4'($urandom_range(0, 15));
      data_wdata_i = $urandom;
      drive(ir, dr, g, rv, $urandom);

      lreq = (m_lock_vld != 0) && ((m_lock_src == 0) ? ir : dr);
      if (lreq)          sel = m_lock_src;
      else if (ir && dr) sel = 1 - m_last;
      else               sel = ir ? 0 : 1;
      e_req = (ir || dr) && (m_q.size() < MO);
      e_gr  = e_req && g;
      e_pop = rv && (m_q.size() > 0);
      ex[4] = e_req;
      ex[3] = e_gr && (sel == 0);
      ex[2] = e_gr && (sel == 1);
      ex[1] = e_pop && (m_q[0] == 0);
      ex[0] = e_pop && (m_q[0] == 1);
      e_out = m_q.size();

      #4;
      chk_hs($sformatf("rnd%0d", cyc), ex, e_out);
      chk($sformatf("rnd%0d.err", cyc), 64'(err_o), 64'(m_err));
      chk($sformatf("rnd%0d.instr_rdata", cyc), 64'(instr_rdata_o), 64'(mem_rdata_i));
      chk($sformatf("rnd%0d.data_rdata", cyc),  64'(data_rdata_o),  64'(mem_rdata_i));
      if (e_req) begin
        if (sel == 0) begin
          chk($sformatf("rnd%0d.addr", cyc),  64'(mem_addr_o),  64'(instr_addr_i));
          chk($sformatf("rnd%0d.we", cyc),    64'(mem_we_o),    64'(0));
          chk($sformatf("rnd%0d.be", cyc),    64'(mem_be_o),    64'(4'hF));
          chk($sformatf("rnd%0d.wdata", cyc), 64'(mem_wdata_o), 64'(0));
        end else begin
          chk($sformatf("rnd%0d.addr", cyc),  64'(mem_addr_o),  64'(data_addr_i));
          chk($sformatf("rnd%0d.we", cyc),    64'(mem_we_o),    64'(data_we_i));
          chk($sformatf("rnd%0d.be", cyc),    64'(mem_be_o),    64'(data_be_i));
          chk($sformatf("rnd%0d.wdata", cyc), 64'(mem_wdata_o), 64'(data_wdata_i));
        end
      end
      $display("rnd%0d: in=%0b%0b%0b%0b req=%0b igt=%0b dgt=%0b irv=%0b drv=%0b out=%0d err=%0b",
               cyc, ir, dr, g, rv, mem_req_o, instr_gnt_o, data_gnt_o,
               instr_rvalid_o, data_rvalid_o, outstanding_o, err_o);
      tick();

      // Advance the model: responses retire the oldest, grants append.
      if (rv && (m_q.size() == 0)) m_err = 1;
      if (e_pop) void'(m_q.pop_front());
      if (e_gr) begin
        m_q.push_back(sel);
        m_last = sel;
      end
      // A refused request stays selected until it is granted or withdrawn.
      m_lock_vld = (e_req && !g) ? 1 : 0;
      m_lock_src = sel;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
